regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_mp_scoreboard.sv | 51 +++++
 rtl/regfile_mp.sv | 101 ++++++++++
 tb/tb_regfile_mp.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the multi-port register file.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NUM_RD_DEF = 2;

  function automatic int byte_count(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/regfile_mp_scoreboard.sv
// Busy-bit scoreboard: set by producer allocation, cleared by strobed writes.
import regfile_pkg::*;

module rf_scoreboard #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = NUM_RD_DEF,
  parameter int NB     = byte_count(DATA_W_DEF)
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     i_alloc_valid,
  input  logic [ADDR_W-1:0]        i_alloc_addr,
  input  logic [1:0]               i_we,
  input  logic [2*ADDR_W-1:0]      i_waddr,
  input  logic [2*NB-1:0]          i_wstrb,
  input  logic [NUM_RD*ADDR_W-1:0] i_raddr,
  output logic [NUM_RD-1:0]        o_rbusy
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_nxt;

  // Clears are applied before the set so a same-cycle allocation keeps the bit.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int p = 0; p < 2; p++) begin
      if (i_we[p] && (|i_wstrb[p*NB +: NB])) begin
        w_busy_nxt[i_waddr[p*ADDR_W +: ADDR_W]] = 1'b0;
      end
    end
    if (i_alloc_valid) begin
      w_busy_nxt[i_alloc_addr] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    assign o_rbusy[gi] = r_busy[i_raddr[gi*ADDR_W +: ADDR_W]];
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: two byte-strobed write ports, NUM_RD read ports,
// optional write-to-read forwarding and a producer busy scoreboard.
import regfile_pkg::*;

module regfile_mp #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = NUM_RD_DEF,
  parameter int BYPASS = 1
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic [NUM_RD*ADDR_W-1:0]           raddr,
  output logic [NUM_RD*DATA_W-1:0]           rdata,
  output logic [NUM_RD-1:0]                  rbusy,
  input  logic [1:0]                         we,
  input  logic [2*ADDR_W-1:0]                waddr,
  input  logic [2*DATA_W-1:0]                wdata,
  input  logic [2*byte_count(DATA_W)-1:0]    wstrb,
  input  logic                               alloc_valid,
  input  logic [ADDR_W-1:0]                  alloc_addr
);

  localparam int NB    = byte_count(DATA_W);
  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] w_waddr [2];
  logic [DATA_W-1:0] w_wdata [2];
  logic [NB-1:0]     w_wstrb [2];

  for (genvar gp = 0; gp < 2; gp++) begin : g_wp
    assign w_waddr[gp] = waddr[gp*ADDR_W +: ADDR_W];
    assign w_wdata[gp] = wdata[gp*DATA_W +: DATA_W];
    assign w_wstrb[gp] = wstrb[gp*NB +: NB];
  end

  // Port 1 is visited last, so its byte lanes win on a same-address overlap.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int a = 0; a < DEPTH; a++) begin
        r_mem[a] <= '0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (we[p] && (w_waddr[p] != '0)) begin
          for (int b = 0; b < NB; b++) begin
            if (w_wstrb[p][b]) begin
              r_mem[w_waddr[p]][b*8 +: 8] <= w_wdata[p][b*8 +: 8];
            end
          end
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] w_raddr;
    logic [DATA_W-1:0] w_rd;

    assign w_raddr = raddr[gi*ADDR_W +: ADDR_W];

    // Writes held during reset are discarded, so they are not forwarded either.
    always_comb begin
      w_rd = r_mem[w_raddr];
      if ((BYPASS != 0) && resetn) begin
        for (int p = 0; p < 2; p++) begin
          if (we[p] && (w_waddr[p] == w_raddr)) begin
            for (int b = 0; b < NB; b++) begin
              if (w_wstrb[p][b]) begin
                w_rd[b*8 +: 8] = w_wdata[p][b*8 +: 8];
              end
            end
          end
        end
      end
      if (w_raddr == '0) begin
        w_rd = '0;
      end
    end

    assign rdata[gi*DATA_W +: DATA_W] = w_rd;
  end

  rf_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD),
    .NB     (NB)
  ) u_scoreboard (
    .clk           (clk),
    .resetn        (resetn),
    .i_alloc_valid (alloc_valid),
    .i_alloc_addr  (alloc_addr),
    .i_we          (we),
    .i_waddr       (waddr),
    .i_wstrb       (wstrb),
    .i_raddr       (raddr),
    .o_rbusy       (rbusy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench: directed cases then random traffic against an array model,
// driving a forwarding and a non-forwarding instance from the same stimulus.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        resetn;
  logic [9:0]  raddr;
  logic [1:0]  we;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        alloc_valid;
  logic [4:0]  alloc_addr;
  wire  [63:0] rdata_b, rdata_n;
  wire  [1:0]  rbusy_b, rbusy_n;

  always #5 clk = ~clk;

  regfile_mp #(.BYPASS(1)) u_dut_byp (
    .clk(clk), .resetn(resetn), .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
    .we(we), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
    .alloc_valid(alloc_valid), .alloc_addr(alloc_addr));

  regfile_mp #(.BYPASS(0)) u_dut_nb (
    .clk(clk), .resetn(resetn), .raddr(raddr), .rdata(rdata_n), .rbusy(rbusy_n),
    .we(we), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
    .alloc_valid(alloc_valid), .alloc_addr(alloc_addr));

  typedef struct {
    string       tag;
    logic [31:0] rb0, rb1, rn0, rn1;
    logic        bs0, bs1;
  } exp_t;

  exp_t        q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_mem [32];
  bit          m_busy [32];

  function automatic void model_clear();
    for (int a = 0; a < 32; a++) begin
      m_mem[a]  = '0;
      m_busy[a] = 1'b0;
    end
  endfunction

  // Applies the inputs that were present at the edge just passed.
  function automatic void model_commit();
    int a;
    if (!resetn) return;
    for (int p = 0; p < 2; p++) begin
      a = int'(waddr[p*5 +: 5]);
      if (we[p] && a != 0) begin
        for (int b = 0; b < 4; b++)
          if (wstrb[p*4+b]) m_mem[a][b*8 +: 8] = wdata[p*32 + b*8 +: 8];
        if (wstrb[p*4 +: 4] != 4'h0) m_busy[a] = 1'b0;
      end
    end
    if (alloc_valid && alloc_addr != 5'd0) m_busy[alloc_addr] = 1'b1;
  endfunction

  function automatic logic [31:0] exp_data(input int a, input bit byp);
    logic [31:0] v;
    if (a == 0) return 32'h0;
    v = m_mem[a];
    if (byp && resetn) begin
      for (int p = 0; p < 2; p++)
        if (we[p] && int'(waddr[p*5 +: 5]) == a)
          for (int b = 0; b < 4; b++)
            if (wstrb[p*4+b]) v[b*8 +: 8] = wdata[p*32 + b*8 +: 8];
    end
    return v;
  endfunction

  task automatic push(input string tag);
    exp_t e;
    int a0, a1;
    a0 = int'(raddr[4:0]);
    a1 = int'(raddr[9:5]);
    e.tag = tag;
    e.rb0 = exp_data(a0, 1'b1);
    e.rb1 = exp_data(a1, 1'b1);
    e.rn0 = exp_data(a0, 1'b0);
    e.rn1 = exp_data(a1, 1'b0);
    e.bs0 = m_busy[a0];
    e.bs1 = m_busy[a1];
    q.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    model_commit();
  endtask

  task automatic idle();
    we = 2'b00; wstrb = 8'h00; alloc_valid = 1'b0;
  endtask

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk({e.tag, " rdata0 byp"}, rdata_b[31:0],  e.rb0);
      chk({e.tag, " rdata1 byp"}, rdata_b[63:32], e.rb1);
      chk({e.tag, " rdata0 nobyp"}, rdata_n[31:0],  e.rn0);
      chk({e.tag, " rdata1 nobyp"}, rdata_n[63:32], e.rn1);
      chk({e.tag, " rbusy byp"},  {30'd0, rbusy_b}, {30'd0, e.bs1, e.bs0});
      chk({e.tag, " rbusy nobyp"}, {30'd0, rbusy_n}, {30'd0, e.bs1, e.bs0});
    end
  end

  initial begin
    resetn = 1'b0; raddr = '0; waddr = '0; wdata = '0; alloc_addr = '0;
    idle();
    model_clear();
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    for (int i = 0; i < 16; i++) begin
      next_cycle();
      raddr = {5'(i + 16), 5'(i)};
      push("reset_read");
    end

    next_cycle();
    we = 2'b01; waddr = {5'd0, 5'd1}; wdata = {32'h0, 32'h1111ffff}; wstrb = 8'h0f;
    raddr = {5'd1, 5'd1};
    push("wr1_same");
    next_cycle(); idle(); push("wr1_next");

    next_cycle();
    we = 2'b11; waddr = {5'd16, 5'd16}; wdata = {32'h22223333, 32'h0000ffff}; wstrb = 8'h3f;
    raddr = {5'd16, 5'd16};
    push("merge_same");
    next_cycle(); idle(); push("merge_next");

    next_cycle();
    we = 2'b01; waddr = {5'd0, 5'd0}; wdata = {32'h0, 32'hffffffff}; wstrb = 8'h0f;
    alloc_valid = 1'b1; alloc_addr = 5'd0; raddr = {5'd0, 5'd0};
    push("reg0_same");
    next_cycle(); idle(); push("reg0_next");

    next_cycle();
    alloc_valid = 1'b1; alloc_addr = 5'd5; raddr = {5'd5, 5'd5};
    push("alloc5");
    next_cycle();
    we = 2'b01; waddr = {5'd0, 5'd5}; wdata = {32'h0, $urandom}; wstrb = 8'h0f;
    push("alloc5_busy");
    next_cycle(); alloc_valid = 1'b0; push("wr_alloc5");
    next_cycle(); idle(); push("wr5_clear");

    next_cycle(); alloc_valid = 1'b1; alloc_addr = 5'd6; raddr = {5'd6, 5'd6}; push("alloc6");
    next_cycle(); idle(); we = 2'b10; waddr = {5'd6, 5'd0}; wdata = {32'hdeadbeef, 32'h0};
    wstrb = 8'h00; push("zero_strb");
    next_cycle(); idle(); push("zero_strb_next");

    next_cycle();
    we = 2'b01; waddr = {5'd0, 5'd20}; wdata = {32'h0, 32'h4444ffff}; wstrb = 8'h0f;
    alloc_valid = 1'b1; alloc_addr = 5'd20; raddr = {5'd20, 5'd20};
    push("wr20_same");
    next_cycle(); idle(); push("wr20_stored");
    next_cycle();
    resetn = 1'b0; model_clear();
    we = 2'b01; alloc_valid = 1'b1;
    push("mid_reset");
    next_cycle(); resetn = 1'b1; idle(); push("post_reset");

    for (int c = 0; c < 600; c++) begin
      next_cycle();
      if ($urandom_range(0, 99) < 2) begin
        resetn = 1'b0;
        model_clear();
      end else begin
        resetn = 1'b1;
      end
      we    = 2'($urandom_range(0, 3));
      waddr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      if ($urandom_range(0, 3) == 0) waddr[9:5] = waddr[4:0];
      wdata = {$urandom, $urandom};
      wstrb = 8'($urandom);
      if ($urandom_range(0, 7) == 0) wstrb[3:0] = 4'h0;
      alloc_valid = ($urandom_range(0, 2) == 0);
      alloc_addr  = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0) raddr = waddr;
      else raddr = {5'($urandom_range(0, 31)), 5'($urandom_range(0, 7))};
      push("random");
    end

    next_cycle(); idle(); resetn = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending entries expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
